// File: rtl/opsel_pkg.sv
// Shared helpers for the pipelined N:1 operand selector.
// Select-width function and the zero word returned on bad selects.
package opsel_pkg;

  localparam int OPSEL_MAX_W = 1024;

  // Zero fill returned for out-of-range selects; slice to WIDTH.
  localparam logic [OPSEL_MAX_W-1:0] ZERO_WORD = '0;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/opsel_skid_buf.sv
// Generic 2-entry valid/ready skid stage; in_ready is a flop output.
// Ports: clk, rst_n, in_beat/in_valid/in_ready, out_beat/out_valid/out_ready.
module opsel_skid_buf #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_beat,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_beat,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          r_main_v;
  logic          r_skid_v;
  logic          w_acc;
  logic          w_load;

  assign in_ready  = !r_skid_v;
  assign out_beat  = r_main;
  assign out_valid = r_main_v;
  assign w_acc     = in_valid && !r_skid_v;
  // Main register is free to take a new beat this edge.
  assign w_load    = !r_main_v || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_load) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_acc) begin
        r_main   <= in_beat;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid   <= in_beat;
      r_skid_v <= 1'b1;
    end
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Pipelined N:1 operand selector with registered valid/ready output.
// Ports: clk, rst_n, in_data/in_sel/in_valid/in_ready,
// out_data/out_sel_err/out_valid/out_ready, err_cnt.
// OPSEL_SKID_EN adds a skid entry so in_ready is registered.
module operand_sel_pipe
  import opsel_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int WIDTH     = 32,
  parameter int SEL_W     = sel_width(N_IN),
  parameter int ERR_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel_err;
  } beat_t;

  beat_t                w_beat;
  logic                 w_acc;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  always_comb begin
    w_beat.data    = ZERO_WORD[WIDTH-1:0];
    w_beat.sel_err = 32'(in_sel) >= 32'(N_IN);
    for (int k = 0; k < N_IN; k++) begin
      if (32'(in_sel) == k)
        w_beat.data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_acc   = in_valid && in_ready;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (w_acc && w_beat.sel_err && r_err_cnt != '1)
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end

`ifdef OPSEL_SKID_EN
  beat_t w_out_beat;

  opsel_skid_buf #(
    .DW($bits(beat_t))
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_beat  (w_beat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_beat (w_out_beat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data    = w_out_beat.data;
  assign out_sel_err = w_out_beat.sel_err;
`else
  beat_t r_beat;
  logic  r_valid;

  assign in_ready    = !r_valid || out_ready;
  assign out_data    = r_beat.data;
  assign out_sel_err = r_beat.sel_err;
  assign out_valid   = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_beat  <= w_beat;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/operand_sel_pipe.md
Name: operand_sel_pipe

Overview:
- Parametrised, pipelined N:1 operand selector for the RISC-V PE datapath and CGRA operand routing.
- Generalises the 3:1 combinational select to N_IN channels of WIDTH bits.
- The selected word is registered behind a valid/ready handshake.
- Out-of-range selects return zero and are flagged on the output beat; a saturating counter tracks them.

Parameters:
- N_IN, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- SEL_W, $clog2(N_IN) (minimum 1), select width.
- ERR_CNT_W, 16, width of the out-of-range select counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel index.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  WIDTH  registered selected word.
- out_sel_err  out  1  the beat on out_data had in_sel >= N_IN.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- err_cnt  out  ERR_CNT_W  saturating count of accepted beats with an out-of-range select.

Behaviour:
- Reset (async assert, sync deassert by the integrator): out_valid=0, out_data=0, out_sel_err=0, err_cnt=0, skid stage empty.
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready at a rising edge.
- Select: word = channel[in_sel] when in_sel < N_IN, otherwise 0 with sel_err=1. Evaluated at acceptance; later changes to in_data/in_sel have no effect on an accepted beat.
- Latency: a beat accepted at edge t is visible on out_data/out_valid after edge t (1 cycle).
- Base pipe (macro absent):
  - in_ready = !out_valid || out_ready (combinational).
  - Accept loads the output register and sets out_valid=1.
  - Deliver without accept clears out_valid and holds out_data.
  - Deliver and accept on the same edge reloads the register; no bubble.
- Stall: while out_valid && !out_ready, out_data and out_sel_err are held stable.
- err_cnt: increments by 1 on each accepted beat with sel_err=1. Saturates at all-ones; no wrap.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset mid-operation: any in-flight or skidded beat is discarded; err_cnt returns to 0.
- Non-power-of-two N_IN: the sel codes N_IN..2^SEL_W-1 form the error range (for example, code 3 when N_IN=3).

Optional Feature:
- Macro OPSEL_SKID_EN adds a one-entry skid register so that in_ready is a flop output, with no combinational out_ready -> in_ready path.
- With the macro:
  - in_ready = !skid_valid (registered).
  - An accept while the main register is stalled writes the skid register.
  - When the main register delivers, it refills from skid if skid_valid, else from the input.
  - Order is strictly FIFO; capacity is 2 beats.
  - Reset clears skid_valid, and with it in_ready is 1 out of reset.
- Without the macro: base pipe only; capacity is 1 beat.

Decomposition:
- Package opsel_pkg:
  - function sel_width(n) for SEL_W.
  - localparam-style constant ZERO_WORD.
  - typedef of the beat struct {data, sel_err} parameterised via WIDTH.
- Natural sub-module: opsel_skid_buf, a generic 2-entry valid/ready skid stage holding the beat struct.
  - Instantiated only under OPSEL_SKID_EN.
  - Otherwise a single pipe register is used.

Test Plan:
- Basic select: N_IN=4, channels = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid pulse, out_ready=1 -> next cycle out_data=0x33333333, out_valid=1, out_sel_err=0, then out_valid=0.
- Out-of-range: N_IN=3, sel=3 -> out_data=0, out_sel_err=1, err_cnt=1. With ERR_CNT_W=2, 5 such beats -> err_cnt=3 (saturated).
- Backpressure: stream sel=0,1,2,3 with out_ready=0 for 3 cycles.
  - Macro absent: in_ready=0 after first accept; out_data stays 0x11111111.
  - Macro present: 2 beats buffered, in_ready=0 on the next edge.
  - Both cases: release out_ready -> all 4 beats delivered in order, none lost or duplicated.
- Full throughput: out_ready=1, in_valid=1 for 8 cycles with sel cycling 0..3 -> 8 consecutive out_valid beats matching the selected channels, 1-cycle latency.
- Input change after accept: accept sel=1, then change in_data channel 1 to 0xDEADBEEF while stalled -> delivered word remains 0x22222222.
- Reset mid-stream: assert rst_n=0 asynchronously with 2 beats in flight -> out_valid=0 and err_cnt=0 immediately. After release, no stale beat is delivered.
